// File: rtl/nkmd_ddr3_dma_pkg.sv
// Shared constants for the nkmd DDR3 DMA bridge: FSM encodings, register map,
// CTRL/STATUS bit positions and MIG command opcodes.
package nkmd_ddr3_dma_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_PRIME    = 3'd2;
    localparam logic [2:0] ST_FILL     = 3'd3;
    localparam logic [2:0] ST_WAIT_CMD = 3'd4;
    localparam logic [2:0] ST_CMD      = 3'd5;
    localparam logic [2:0] ST_RD_WAIT  = 3'd6;
    localparam logic [2:0] ST_NEXT     = 3'd7;

    localparam logic [1:0] REG_DADDR = 2'd0;
    localparam logic [1:0] REG_SADDR = 2'd1;
    localparam logic [1:0] REG_LEN   = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_DIR      = 1;
    localparam int CTRL_CLR_ERR  = 2;
    localparam int CTRL_CLR_DONE = 3;

    localparam int STAT_IDLE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_DONE = 3;

    localparam logic [2:0] MIG_INSTR_WR = 3'b000;
    localparam logic [2:0] MIG_INSTR_RD = 3'b001;

endpackage

// File: rtl/nkmd_dpram.sv
// True dual-port synchronous RAM with registered reads; on a same-address
// double write, port A takes priority.
module nkmd_dpram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic [DW-1:0] b_rdata_o
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk_i) begin
        if (b_we_i) mem[b_addr_i] <= b_wdata_i;
        if (a_we_i) mem[a_addr_i] <= a_wdata_i;
        a_rdata_o <= mem[a_addr_i];
        b_rdata_o <= mem[b_addr_i];
    end

endmodule

// File: rtl/nkmd_ddr3_dma.sv
// Scratchpad plus multi-burst DMA engine onto a 32-bit MIG user port.
// Optional NKMD_DDR3_DMA_IRQ_EN adds a done flag (STATUS bit3) and an irq output.
module nkmd_ddr3_dma
    import nkmd_ddr3_dma_pkg::*;
#(
    parameter int          SPAD_AW   = 10,
    parameter int          MAX_BURST = 64,
    parameter logic [3:0]  SPAD_PAGE = 4'h1,
    parameter logic [15:0] REG_BASE  = 16'hc100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mig_cmd_clk,
    output logic        mig_cmd_en,
    output logic [2:0]  mig_cmd_instr,
    output logic [5:0]  mig_cmd_bl,
    output logic [29:0] mig_cmd_byte_addr,
    input  logic        mig_cmd_empty,
    input  logic        mig_cmd_full,
    output logic        mig_wr_clk,
    output logic        mig_wr_en,
    output logic [3:0]  mig_wr_mask,
    output logic [31:0] mig_wr_data,
    input  logic        mig_wr_full,
    input  logic        mig_wr_empty,
    input  logic        mig_wr_underrun,
    input  logic        mig_wr_error,
    input  logic [6:0]  mig_wr_count,
    output logic        mig_rd_clk,
    output logic        mig_rd_en,
    input  logic [31:0] mig_rd_data,
    input  logic        mig_rd_full,
    input  logic        mig_rd_empty,
    input  logic        mig_rd_overflow,
    input  logic        mig_rd_error,
    input  logic [6:0]  mig_rd_count,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [15:0] addr_i,
    input  logic        we_i
`ifdef NKMD_DDR3_DMA_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int RW = SPAD_AW + 1;

    logic [2:0]         state_q, state_d;
    logic [27:0]        daddr_q, daddr_d, waddr_q, waddr_d;
    logic [SPAD_AW-1:0] saddr_q, saddr_d, wptr_q, wptr_d, ram_b_addr;
    logic [RW-1:0]      len_q, len_d, rem_q, rem_d;
    logic [6:0]         burst_q, burst_d, cnt_q, cnt_d, burst_n;
    logic               dir_q, dir_d, err_q, err_d, done_q, done_set;
    logic               spad_rd_q, ram_we;
    logic [31:0]        reg_rd_q, reg_rd_d, status, ram_a_rdata, ram_b_rdata;
    logic               spad_sel, reg_sel, busy, ctrl_wr, start, err_set;
    logic [1:0]         reg_off;
    logic               unused_ok;

    assign spad_sel = addr_i[15:12] == SPAD_PAGE;
    assign reg_sel  = addr_i[15:2] == REG_BASE[15:2];
    assign reg_off  = addr_i[1:0];
    assign busy     = state_q != ST_IDLE;
    assign ctrl_wr  = we_i && reg_sel && reg_off == REG_CTRL;
    assign start    = ctrl_wr && data_i[CTRL_START] && !busy;
    assign err_set  = mig_wr_underrun | mig_wr_error | mig_rd_overflow | mig_rd_error;
    assign burst_n  = (rem_q > RW'(MAX_BURST)) ? 7'(MAX_BURST) : 7'(rem_q);
    assign unused_ok = ^{mig_cmd_empty, mig_wr_empty, mig_wr_count, mig_rd_full, mig_rd_count};

    assign mig_cmd_clk       = clk;
    assign mig_wr_clk        = clk;
    assign mig_rd_clk        = clk;
    assign mig_wr_mask       = 4'b0000;
    assign mig_wr_data       = ram_b_rdata;
    assign mig_cmd_instr     = dir_q ? MIG_INSTR_WR : MIG_INSTR_RD;
    assign mig_cmd_bl        = 6'(burst_q - 7'd1);
    assign mig_cmd_byte_addr = {waddr_q, 2'b00};
    assign data_o            = spad_rd_q ? ram_a_rdata : reg_rd_q;

    // Look one word ahead when a FILL word is accepted so the RAM output is
    // already on the next word at the following edge.
    assign ram_b_addr = wptr_q + SPAD_AW'(mig_wr_en);

    always_comb begin
        status = '0;
        status[STAT_IDLE] = !busy;
        status[STAT_BUSY] = busy;
        status[STAT_ERR]  = err_q;
        status[STAT_DONE] = done_q;
        status[31:16]     = 16'(rem_q);
    end

    always_comb begin
        daddr_d = daddr_q;
        saddr_d = saddr_q;
        len_d   = len_q;
        if (we_i && reg_sel && !busy) begin
            case (reg_off)
                REG_DADDR: daddr_d = data_i[29:2];
                REG_SADDR: saddr_d = data_i[SPAD_AW-1:0];
                REG_LEN:   len_d   = data_i[RW-1:0];
                default:   ;
            endcase
        end
        err_d = err_set | (err_q & !(ctrl_wr & data_i[CTRL_CLR_ERR]));
        reg_rd_d = '0;
        if (reg_sel) begin
            case (reg_off)
                REG_DADDR: reg_rd_d = {2'b00, daddr_q, 2'b00};
                REG_SADDR: reg_rd_d = 32'(saddr_q);
                REG_LEN:   reg_rd_d = 32'(len_q);
                default:   reg_rd_d = status;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        wptr_d     = wptr_q;
        rem_d      = rem_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        done_set   = 1'b0;
        mig_cmd_en = 1'b0;
        mig_wr_en  = 1'b0;
        mig_rd_en  = 1'b0;
        ram_we     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                waddr_d = daddr_q;
                wptr_d  = saddr_q;
                rem_d   = len_q;
                dir_d   = data_i[CTRL_DIR];
                if (len_q == '0) done_set = 1'b1;
                else             state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                burst_d = burst_n;
                cnt_d   = '0;
                state_d = dir_q ? ST_PRIME : ST_WAIT_CMD;
            end
            ST_PRIME: state_d = ST_FILL;
            ST_FILL: if (!mig_wr_full) begin
                mig_wr_en = 1'b1;
                wptr_d    = wptr_q + SPAD_AW'(1);
                cnt_d     = cnt_q + 7'd1;
                if (cnt_q == burst_q - 7'd1) state_d = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: if (!mig_cmd_full) state_d = ST_CMD;
            ST_CMD: begin
                mig_cmd_en = 1'b1;
                cnt_d      = '0;
                state_d    = dir_q ? ST_NEXT : ST_RD_WAIT;
            end
            ST_RD_WAIT: if (!mig_rd_empty) begin
                mig_rd_en = 1'b1;
                ram_we    = 1'b1;
                wptr_d    = wptr_q + SPAD_AW'(1);
                cnt_d     = cnt_q + 7'd1;
                if (cnt_q == burst_q - 7'd1) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                waddr_d = waddr_q + 28'(burst_q);
                rem_d   = rem_q - RW'(burst_q);
                if (rem_q == RW'(burst_q)) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    state_d  = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            daddr_q   <= '0;
            saddr_q   <= '0;
            len_q     <= '0;
            waddr_q   <= '0;
            wptr_q    <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            spad_rd_q <= 1'b0;
            reg_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            daddr_q   <= daddr_d;
            saddr_q   <= saddr_d;
            len_q     <= len_d;
            waddr_q   <= waddr_d;
            wptr_q    <= wptr_d;
            rem_q     <= rem_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            spad_rd_q <= spad_sel;
            reg_rd_q  <= reg_rd_d;
        end
    end

`ifdef NKMD_DDR3_DMA_IRQ_EN
    logic done_d;

    always_comb begin
        done_d = done_q;
        if (start || (ctrl_wr && data_i[CTRL_CLR_DONE])) done_d = 1'b0;
        if (done_set) done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done_d;
    end

    assign irq = done_q | err_q;
`else
    logic unused_done;
    assign done_q      = 1'b0;
    assign unused_done = done_set;
`endif

    nkmd_dpram #(.AW(SPAD_AW), .DW(32)) u_spad (
        .clk_i     (clk),
        .a_we_i    (we_i && spad_sel),
        .a_addr_i  (addr_i[SPAD_AW-1:0]),
        .a_wdata_i (data_i),
        .a_rdata_o (ram_a_rdata),
        .b_we_i    (ram_we),
        .b_addr_i  (ram_b_addr),
        .b_wdata_i (mig_rd_data),
        .b_rdata_o (ram_b_rdata)
    );

endmodule

// File: tb/tb_nkmd_ddr3_dma.sv
// Self-checking bench for nkmd_ddr3_dma: register/scratchpad vector table, directed
// corner cases and randomized transfers checked against a burst-splitting reference model.
module tb_nkmd_ddr3_dma;

    localparam int MAXB = 64;
    localparam logic [31:0] SMASK = 32'hffff_fff7;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        mig_cmd_clk, mig_cmd_en, mig_wr_clk, mig_wr_en, mig_rd_clk, mig_rd_en;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl;
    logic [29:0] mig_cmd_byte_addr;
    logic [3:0]  mig_wr_mask;
    logic [31:0] mig_wr_data, mig_rd_data, data_o;
    logic        mig_cmd_full = 1'b0, mig_rd_overflow = 1'b0;
    logic        mig_wr_full, mig_rd_empty;
    logic [31:0] data_i = '0;
    logic [15:0] addr_i = '0;
    logic        we_i = 1'b0;
`ifdef NKMD_DDR3_DMA_IRQ_EN
    logic        irq;
`endif

    // MIG-side behavioural model
    logic        wr_full_r = 1'b0, rd_tog = 1'b0, stall_en = 1'b0, tog_en = 1'b0;
    int          rd_pops = 0, rd_avail = 0, ncmd = 0, nwr = 0, viol = 0;
    logic [31:0] rd_mem [0:4095];
    logic [31:0] wlog [0:4095];
    logic [2:0]  c_instr [0:255];
    logic [5:0]  c_bl [0:255];
    logic [29:0] c_addr [0:255];
    logic [31:0] spad [0:1023];

    assign mig_wr_full  = wr_full_r;
    assign mig_rd_empty = (rd_pops >= rd_avail) || (tog_en && rd_tog);
    assign mig_rd_data  = rd_mem[12'(rd_pops)];

    always @(posedge clk) begin
        if (mig_cmd_en) begin
            if (mig_cmd_full) viol++;
            c_instr[8'(ncmd)] = mig_cmd_instr;
            c_bl[8'(ncmd)]    = mig_cmd_bl;
            c_addr[8'(ncmd)]  = mig_cmd_byte_addr;
            ncmd++;
        end
        if (mig_wr_en) begin
            if (mig_wr_full) viol++;
            wlog[12'(nwr)] = mig_wr_data;
            nwr++;
        end
        if (mig_rd_en) begin
            if (mig_rd_empty) viol++;
            rd_pops <= rd_pops + 1;
        end
        rd_tog    <= ~rd_tog;
        wr_full_r <= stall_en && ($urandom_range(0, 1) == 1);
    end

    nkmd_ddr3_dma dut (
        .clk(clk), .rst(rst),
        .mig_cmd_clk(mig_cmd_clk), .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr),
        .mig_cmd_bl(mig_cmd_bl), .mig_cmd_byte_addr(mig_cmd_byte_addr),
        .mig_cmd_empty(1'b0), .mig_cmd_full(mig_cmd_full),
        .mig_wr_clk(mig_wr_clk), .mig_wr_en(mig_wr_en), .mig_wr_mask(mig_wr_mask),
        .mig_wr_data(mig_wr_data), .mig_wr_full(mig_wr_full), .mig_wr_empty(1'b0),
        .mig_wr_underrun(1'b0), .mig_wr_error(1'b0), .mig_wr_count(7'd0),
        .mig_rd_clk(mig_rd_clk), .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data),
        .mig_rd_full(1'b0), .mig_rd_empty(mig_rd_empty), .mig_rd_overflow(mig_rd_overflow),
        .mig_rd_error(1'b0), .mig_rd_count(7'd0),
        .data_i(data_i), .data_o(data_o), .addr_i(addr_i), .we_i(we_i)
`ifdef NKMD_DDR3_DMA_IRQ_EN
        , .irq(irq)
`endif
    );

    int nchk = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        addr_i = a; data_i = d; we_i = 1'b1;
        tick();
        we_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        addr_i = a; we_i = 1'b0;
        tick();
        d = data_o;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_rd(16'hc103, s);
            n++;
        end while (!s[0] && n < 3000);
        chk({name, "_idle"}, 32'(s[0]), 32'd1);
    endtask

    // Reference: split len into bursts of at most MAXB, DRAM address stepping 4 bytes/word mod 2^30.
    task automatic run_xfer(input string name, input logic dir, input logic [31:0] daddr,
                            input int saddr, input int len, input logic stall, input logic tog);
        int c0, w0, p0, bad, nb, off, b;
        logic [29:0] ea;
        logic [31:0] d;
        c0 = ncmd; w0 = nwr; p0 = rd_pops;
        if (!dir) begin
            for (int i = 0; i < len; i++) rd_mem[12'(p0 + i)] = $urandom;
            rd_avail = p0 + len;
        end
        stall_en = stall; tog_en = tog;
        bus_wr(16'hc100, daddr);
        bus_wr(16'hc101, 32'(saddr));
        bus_wr(16'hc102, 32'(len));
        bus_wr(16'hc103, {30'd0, dir, 1'b1});
        wait_idle(name);
        stall_en = 1'b0; tog_en = 1'b0;
        bad = 0; nb = 0; off = 0;
        while (off < len) begin
            b  = (len - off > MAXB) ? MAXB : len - off;
            ea = (daddr[29:0] & 30'h3fff_fffc) + 30'(off * 4);
            if (c0 + nb >= ncmd || c_instr[8'(c0 + nb)] !== (dir ? 3'b000 : 3'b001) ||
                c_bl[8'(c0 + nb)] !== 6'(b - 1) || c_addr[8'(c0 + nb)] !== ea) bad++;
            nb++; off += b;
        end
        chk({name, "_ncmd"}, 32'(ncmd - c0), 32'(nb));
        chk({name, "_cmds_bad"}, 32'(bad), 32'd0);
        bad = 0;
        if (dir) begin
            chk({name, "_nwr"}, 32'(nwr - w0), 32'(len));
            for (int i = 0; i < len; i++)
                if (wlog[12'(w0 + i)] !== spad[10'((saddr + i) % 1024)]) bad++;
            chk({name, "_wdata_bad"}, 32'(bad), 32'd0);
        end else begin
            chk({name, "_pops"}, 32'(rd_pops - p0), 32'(len));
            for (int i = 0; i < len; i++) spad[10'((saddr + i) % 1024)] = rd_mem[12'(p0 + i)];
            for (int i = 0; i < len; i++) begin
                bus_rd(16'h1000 | 16'((saddr + i) % 1024), d);
                if (d !== spad[10'((saddr + i) % 1024)]) bad++;
            end
            chk({name, "_rdata_bad"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        vec_t v [14];
        logic [31:0] s, dr;
        int c0, w0;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_enables", 32'({mig_cmd_en, mig_wr_en, mig_rd_en}), 32'd0);
        rst = 1'b0;
        tick();
        bus_rd(16'hc103, s);
        chk("rst_status", s & SMASK, 32'h1);

        v[0]  = '{1'b1, 16'hc100, 32'hffff_fff7, 32'h0};
        v[1]  = '{1'b0, 16'hc100, 32'h0, 32'h3fff_fff4};
        v[2]  = '{1'b1, 16'hc101, 32'hffff_ffff, 32'h0};
        v[3]  = '{1'b0, 16'hc101, 32'h0, 32'h0000_03ff};
        v[4]  = '{1'b1, 16'hc102, 32'h0000_ffff, 32'h0};
        v[5]  = '{1'b0, 16'hc102, 32'h0, 32'h0000_07ff};
        v[6]  = '{1'b1, 16'h1005, 32'hdead_beef, 32'h0};
        v[7]  = '{1'b0, 16'h1005, 32'h0, 32'hdead_beef};
        v[8]  = '{1'b1, 16'h1fff, 32'h1234_5678, 32'h0};
        v[9]  = '{1'b0, 16'h13ff, 32'h0, 32'h1234_5678};
        v[10] = '{1'b0, 16'h2000, 32'h0, 32'h0};
        v[11] = '{1'b0, 16'hc104, 32'h0, 32'h0};
        v[12] = '{1'b1, 16'hc0ff, 32'h5555_aaaa, 32'h0};
        v[13] = '{1'b0, 16'hc103, 32'h0, 32'h1};
        for (int i = 0; i < 14; i++) begin
            if (v[i].we) bus_wr(v[i].addr, v[i].wd);
            else begin
                bus_rd(v[i].addr, dr);
                chk($sformatf("vec%0d_%04h", i, v[i].addr), (v[i].addr == 16'hc103) ? (dr & SMASK) : dr, v[i].exp);
            end
        end

        for (int i = 0; i < 1024; i++) begin
            spad[i] = $urandom;
            bus_wr(16'h1000 | 16'(i), spad[i]);
        end

        c0 = ncmd;
        run_xfer("wr100", 1'b1, 32'h400, 0, 100, 1'b0, 1'b0);
        chk("wr100_bl0", 32'(c_bl[8'(c0)]), 32'd63);
        chk("wr100_addr1", 32'(c_addr[8'(c0 + 1)]), 32'h500);
        chk("wr100_bl1", 32'(c_bl[8'(c0 + 1)]), 32'd35);

        run_xfer("rd10", 1'b0, 32'h80, 0, 10, 1'b0, 1'b1);
        chk("rd10_protocol", 32'(viol), 32'd0);

        // Command port back-pressure
        mig_cmd_full = 1'b1;
        c0 = ncmd; w0 = nwr;
        bus_wr(16'hc100, 32'h40);
        bus_wr(16'hc101, 32'h10);
        bus_wr(16'hc102, 32'd4);
        bus_wr(16'hc103, 32'h3);
        repeat (20) tick();
        chk("cf_hold", 32'(ncmd - c0), 32'd0);
        bus_rd(16'hc103, s);
        chk("cf_status", s & SMASK, 32'h0004_0002);
        mig_cmd_full = 1'b0;
        chk("cf_en_at_drop", 32'(mig_cmd_en), 32'd0);
        tick();
        chk("cf_en_next", 32'(mig_cmd_en), 32'd1);
        chk("cf_bl", 32'(mig_cmd_bl), 32'd3);
        wait_idle("cf");
        chk("cf_nwr", 32'(nwr - w0), 32'd4);
        chk("cf_w3", wlog[12'(w0 + 3)], spad[19]);

        run_xfer("wrap_wr", 1'b1, 32'h1000, 1020, 8, 1'b1, 1'b0);
        run_xfer("wrap_rd", 1'b0, 32'h2000, 1020, 8, 1'b0, 1'b1);

        c0 = ncmd;
        bus_wr(16'hc102, 32'd0);
        bus_wr(16'hc103, 32'h3);
        repeat (5) tick();
        chk("zero_len_ncmd", 32'(ncmd - c0), 32'd0);
        bus_rd(16'hc103, s);
        chk("zero_len_status", s & SMASK, 32'h1);

        for (int it = 0; it < 6; it++) begin
            run_xfer($sformatf("rnd%0d", it), 1'(it == 0 ? 1 : $urandom_range(0, 1)),
                     (it == 0) ? 32'h3fff_ff03 : $urandom, int'($urandom_range(0, 1023)),
                     int'($urandom_range(1, 200)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Sticky error
        mig_rd_overflow = 1'b1;
        tick();
        mig_rd_overflow = 1'b0;
        repeat (3) tick();
        bus_rd(16'hc103, s);
        chk("err_set", s & SMASK, 32'h5);
        bus_wr(16'hc103, 32'h4);
        bus_rd(16'hc103, s);
        chk("err_clr", s & SMASK, 32'h1);
        mig_rd_overflow = 1'b1;
        bus_wr(16'hc103, 32'h4);
        mig_rd_overflow = 1'b0;
        bus_rd(16'hc103, s);
        chk("err_set_wins", s & SMASK, 32'h5);

        // Reset in the middle of FILL
        bus_wr(16'hc101, 32'h0);
        bus_wr(16'hc102, 32'd64);
        bus_wr(16'hc103, 32'h3);
        repeat (4) tick();
        chk("pre_rst_wr_en", 32'(mig_wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_en", 32'({mig_cmd_en, mig_wr_en, mig_rd_en}), 32'd0);
        chk("rst_async_data_o", data_o, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus_rd(16'hc103, s);
        chk("post_rst_status", s & SMASK, 32'h1);

        chk("mig_protocol", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nkmd_ddr3_dma.md
Name: nkmd_ddr3_dma

Overview:
- Parametrised successor to the nkmd DDR3 scratchpad bridge. Pairs a bus-visible scratchpad with a multi-burst DMA engine that drives one 32-bit MIG user port.
- Transfers of any length up to the scratchpad depth are split automatically into MIG bursts of at most MAX_BURST words.
- Honours MIG FIFO and command flow control and reports sticky error status.
- Sits on the nkmm bus beside the CPU; the MIG core sits on the other side.

Parameters:
- SPAD_AW, 10, scratchpad address width; depth = 2**SPAD_AW 32-bit words.
- MAX_BURST, 64, maximum words per MIG command; legal range 1..64.
- SPAD_PAGE, 4'h1, value of addr_i[15:12] that selects the scratchpad.
- REG_BASE, 16'hc100, address of the first of four DMA registers.

Ports:
- clk  in  1  single system clock; all MIG port clocks are driven from it.
- rst  in  1  asynchronous, active-high reset.
- mig_cmd_clk/en/instr/bl/byte_addr  out  1/1/3/6/30  MIG command port.
- mig_cmd_empty, mig_cmd_full  in  1 each.
- mig_wr_clk/en/mask/data  out  1/1/4/32  MIG write port.
- mig_wr_full, mig_wr_empty, mig_wr_underrun, mig_wr_error  in  1 each.
- mig_wr_count  in  7.
- mig_rd_clk, mig_rd_en  out  1 each.
- mig_rd_data  in  32.
- mig_rd_full, mig_rd_empty, mig_rd_overflow, mig_rd_error  in  1 each.
- mig_rd_count  in  7.
- data_i  in  32  bus write data.
- data_o  out  32  bus read data, registered.
- addr_i  in  16  bus word address.
- we_i  in  1  bus write strobe.

Behaviour:
- Reset: async reset, active-high.
  - All registers, the FSM and data_o go to 0; state goes to IDLE.
  - mig_cmd_en, mig_wr_en and mig_rd_en are deasserted.
  - Scratchpad contents are not reset.
  - A reset mid-transfer aborts it. The MIG core must be reset alongside this block.
- Bus read latency is 1 cycle: data_o reflects the addr_i of the previous cycle. Unmapped addresses read as 0.
- Scratchpad: selected when addr_i[15:12]==SPAD_PAGE; index is addr_i[SPAD_AW-1:0].
  - The scratchpad is true dual-port: the bus port always wins its own cycle, and the DMA uses the second port.
  - Bus writes into a region under active DMA leave that data undefined but must never stall or hang the engine.
- Registers (offsets from REG_BASE):
  - +0 DADDR: R/W. DRAM byte address; bits [1:0] read 0; bits [29:2] stored.
  - +1 SADDR: R/W. Scratchpad word start address, SPAD_AW bits.
  - +2 LEN: R/W. Transfer length in words, SPAD_AW+1 bits.
  - +3 CTRL (write): bit0 = start; bit1 = dir (1 = spad->DRAM, 0 = DRAM->spad); bit2 = clear error.
  - +3 STATUS (read): bit0 = idle; bit1 = busy; bit2 = error; bits[31:16] = words remaining.
  - Writes to +0..+2 while busy are ignored. A start while busy is ignored.
  - Programmed register values are preserved; the engine works on internal copies.
- FSM states: IDLE, SETUP, PRIME, FILL, WAIT_CMD, CMD, RD_WAIT, NEXT.
  - IDLE: on a start, latch working address/length copies and go to SETUP. LEN==0 returns to IDLE the next cycle with no MIG traffic.
  - SETUP: burst = min(remaining, MAX_BURST). Go to PRIME if writing, else WAIT_CMD.
  - PRIME: issue the first scratchpad read (1-cycle RAM latency).
  - FILL: mig_wr_en=1 for each word while !mig_wr_full; hold the current word when full. After burst words, go to WAIT_CMD.
  - WAIT_CMD: hold until !mig_cmd_full, then go to CMD.
  - CMD: mig_cmd_en=1 for exactly 1 cycle.
    - instr = 3'b000 for a write, 3'b001 for a read.
    - bl = burst-1.
    - byte_addr = working DRAM address.
    - Write goes to NEXT; read goes to RD_WAIT.
  - RD_WAIT: mig_rd_en = !mig_rd_empty. Each pop writes mig_rd_data into the scratchpad and increments the scratchpad pointer. After burst pops, go to NEXT.
  - NEXT:
    - DRAM address += burst*4, wrapping modulo 2**30.
    - Scratchpad pointer wraps modulo the depth.
    - remaining -= burst.
    - If remaining==0 go to IDLE, else go to SETUP.
- Constant outputs: mig_wr_mask = 4'b0000; all mig_*_clk = clk.
- Error: sticky. Set by mig_wr_underrun | mig_wr_error | mig_rd_overflow | mig_rd_error. Cleared by CTRL bit2 or reset.
  - When set and clear occur in the same cycle, set wins.
  - An error does not abort the transfer.

Optional Feature:
- Macro: NKMD_DDR3_DMA_IRQ_EN.
- When defined, output irq (1 bit) is added, plus STATUS bit3 done.
  - done is set on the cycle the FSM enters IDLE from NEXT or from a zero-length start.
  - irq = done | error.
  - done is cleared by writing CTRL bit3=1 or by a new start.
- When not defined: no irq port, and STATUS bit3 reads 0.

Decomposition:
- Package nkmd_ddr3_dma_pkg holds:
  - FSM state encodings.
  - Register offsets (DADDR/SADDR/LEN/CTRL).
  - CTRL/STATUS bit positions.
  - MIG instruction constants: MIG_INSTR_WR=3'b000, MIG_INSTR_RD=3'b001.
- One sub-module: nkmd_dpram, a parametrised dual-port synchronous RAM (width 32, depth 2**SPAD_AW, 1-cycle read) used for the scratchpad.

Test Plan:
- Bus spad write 0xdeadbeef @0x1005, then read @0x1005 -> data_o=0xdeadbeef one cycle after the read address.
- Write LEN=100, SADDR=0, DADDR=0x400, CTRL=0x3 -> two write commands: bl=63 @0x400, then bl=35 @0x500; 100 wr_en pulses with data matching the scratchpad; STATUS idle=1 afterwards.
- Read with LEN=10 and mig_rd_empty toggled every other cycle -> exactly 10 pops land in spad[0..9]; no rd_en while empty.
- mig_cmd_full held high for 20 cycles in WAIT_CMD -> mig_cmd_en stays 0; command issues 1 cycle after full drops; mig_wr_full stall holds FILL without losing words.
- SADDR=1020 with LEN=8 (SPAD_AW=10) -> scratchpad accesses wrap 1020..1023, 0..3. LEN=0 start -> idle next cycle, zero MIG commands.
- Assert rst mid-FILL -> all enables drop asynchronously and STATUS reads idle=1, error=0. Pulse mig_rd_overflow -> error=1 stays latched until CTRL=0x4.
